bsg_cgol_ctrl: RTL
==================

BSG_CGOL_CTRL -- requirements
Module: bsg_cgol_ctrl

Interface
REQ-001 SHALL have parameter max_game_length_p, default 10, giving the maximum number of generations per game.
REQ-002 SHALL derive localparam game_len_width_lp = $clog2(max_game_length_p+1).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port v_i, input, 1 bit: a new game request (board plus length) is valid.
REQ-006 SHALL have port frames_i, input, game_len_width_lp bits: number of generations to simulate.
REQ-007 SHALL have port ready_o, output, 1 bit: the controller can accept a game.
REQ-008 SHALL have port update_o, output, 1 bit: drives update_i of every cell, loading the initial board.
REQ-009 SHALL have port en_o, output, 1 bit: drives en_i of every cell, advancing one generation.
REQ-010 SHALL have port v_o, output, 1 bit: the final board on the cell outputs is valid.
REQ-011 SHALL have port yumi_i, input, 1 bit: the consumer takes the final board; asserted only while v_o=1.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL assert ready_o=1 only in IDLE.
REQ-014 SHALL treat v_i & ready_o as the accept event.
REQ-015 SHALL drive update_o = v_i & ready_o combinationally, so cells load update_val_i on the accept edge.
REQ-016 SHALL, on accept, latch frames_i into a down-counter cnt_r.
REQ-017 SHALL, on accept, go to RUN if frames_i != 0, else go directly to DONE.
REQ-018 SHALL assert en_o=1 in RUN every cycle, and en_o=0 in every other state.
REQ-019 SHALL decrement cnt_r each RUN cycle, and go to DONE on the cycle cnt_r==1.
REQ-020 SHALL therefore produce exactly frames_i en_o pulses per game.
REQ-021 SHALL never assert update_o and en_o in the same cycle.
REQ-022 SHALL assert v_o=1 only in DONE, and hold it until yumi_i=1.
REQ-023 SHALL go DONE->IDLE on yumi_i=1; with v_i high, the next accept occurs no earlier than the cycle after.
REQ-024 SHALL ignore v_i and frames_i outside IDLE; no queuing, and cnt_r is unaffected.
REQ-025 SHALL clamp frames_i > max_game_length_p to max_game_length_p when latched.
REQ-026 SHALL give latency from accept to v_o=1 of exactly frames_i+1 cycles.
REQ-027 SHALL ignore yumi_i when v_o=0.
REQ-028 SHALL have no combinational path from yumi_i to any output.

Reset
REQ-029 SHALL, while reset_n_i=0, asynchronously force state=IDLE and cnt_r=0.
REQ-030 SHALL, while reset_n_i=0, force ready_o=0, update_o=0, en_o=0 and v_o=0.
REQ-031 SHALL assert ready_o=1 in the first cycle after reset_n_i deasserts.
REQ-032 SHALL abort any game in progress on reset mid-RUN or mid-DONE, with no further en_o pulses; cell contents are then don't-care.

Verification
REQ-033 SHALL cover: frames_i=3, v_i=1 in IDLE -> update_o one cycle, en_o high exactly 3 cycles, v_o high on cycle 4 after accept.
REQ-034 SHALL cover: frames_i=0 accepted -> zero en_o pulses, v_o=1 the cycle after accept.
REQ-035 SHALL cover: yumi_i held 0 for 5 cycles in DONE -> v_o stays 1, en_o stays 0; yumi_i=1 -> IDLE, ready_o=1 the next cycle.
REQ-036 SHALL cover: v_i pulsed with frames_i=7 during RUN of a 5-frame game -> still exactly 5 en_o pulses, and no extra update_o.
REQ-037 SHALL cover: reset_n_i low for 1 cycle after 2 of 6 RUN cycles -> en_o=0 immediately (asynchronous), IDLE after release, a new game runs normally.
REQ-038 SHALL cover: frames_i=15 with max_game_length_p=10 -> exactly 10 en_o pulses, with a 7-cell blinker board yielding the period-2 expected pattern.

Source files
------------

// File: rtl/bsg_cgol_ctrl.sv
// Game-of-life cell-array controller: accepts a game request, pulses update_o to
// load the board, runs en_o for the requested number of generations, then holds
// v_o until the consumer takes the final board.
`timescale 1ns / 1ps

module bsg_cgol_ctrl #(
    parameter int unsigned max_game_length_p = 10,
    localparam int unsigned game_len_width_lp = $clog2(max_game_length_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [game_len_width_lp-1:0] frames_i,
    output logic                         ready_o,
    output logic                         update_o,
    output logic                         en_o,
    output logic                         v_o,
    input  logic                         yumi_i
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [game_len_width_lp-1:0] MaxLen = game_len_width_lp'(max_game_length_p);
    localparam logic [game_len_width_lp-1:0] CntOne = game_len_width_lp'(1);
    localparam logic [game_len_width_lp-1:0] CntZero = '0;

    state_e                       state_q, state_d;
    logic [game_len_width_lp-1:0] cnt_q, cnt_d;
    logic [game_len_width_lp-1:0] frames_clamped;
    logic                         accept;

    // Requests longer than the array supports are cut to the maximum game length.
    assign frames_clamped = (frames_i > MaxLen) ? MaxLen : frames_i;

    // ready_o is gated by reset so nothing is accepted or loaded while held in reset.
    assign accept   = v_i & ready_o;
    assign update_o = accept;

    // State and remaining-generation counter; reset aborts any game in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            cnt_q   <= CntZero;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore outputs; yumi_i only steers state_d, never an output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        en_o    = 1'b0;
        v_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_o = reset_n_i;
                if (v_i && reset_n_i) begin
                    cnt_d   = frames_clamped;
                    state_d = (frames_clamped == CntZero) ? StDone : StRun;
                end
            end
            StRun: begin
                en_o  = 1'b1;
                cnt_d = cnt_q - CntOne;
                // Last generation is the one issued while the counter reads one.
                if (cnt_q <= CntOne) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Loading and stepping the cells in the same cycle would corrupt the board.
    a_no_update_and_en : assert property (
        @(posedge clk_i) disable iff (!reset_n_i) !(update_o && en_o)
    );

    // Only one of the three handshake phases may be visible at a time.
    a_phase_onehot : assert property (
        @(posedge clk_i) disable iff (!reset_n_i) $onehot0({ready_o, en_o, v_o})
    );

endmodule
